// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 Set-2 scan-code decoder.
//   ps2_state_e : prefix-tracking FSM states
//   ps2_event_t : one decoded key event {ext, brk, code, ascii}
//   is_status() : true for receiver/keyboard status bytes that carry no key
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } ps2_state_e;

    localparam logic [7:0] CODE_BRK     = 8'hF0;
    localparam logic [7:0] CODE_EXT     = 8'hE0;
    localparam logic [7:0] CODE_SHIFT_L = 8'h12;
    localparam logic [7:0] CODE_SHIFT_R = 8'h59;
    localparam logic [7:0] CODE_CAPS    = 8'h58;

    localparam logic [7:0] ST_ERR0  = 8'h00;
    localparam logic [7:0] ST_BAT   = 8'hAA;
    localparam logic [7:0] ST_ECHO  = 8'hEE;
    localparam logic [7:0] ST_ACK   = 8'hFA;
    localparam logic [7:0] ST_RSND  = 8'hFE;
    localparam logic [7:0] ST_ERR1  = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } ps2_event_t;

    function automatic logic is_status(input logic [7:0] b);
        return (b == ST_ERR0) || (b == ST_BAT)  || (b == ST_ECHO) ||
               (b == ST_ACK)  || (b == ST_RSND) || (b == ST_ERR1);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: show-ahead event stream from the decoder FIFO.
//   ev_code/ev_ext/ev_brk/ev_ascii : head event fields
//   out_valid                      : FIFO not empty
//   out_ready                      : consumer pops head when out_valid is high
//   master = decoder side, slave = consumer side.
interface ps2_scancode_decoder_if;

    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic [7:0] ev_ascii;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output ev_code, ev_ext, ev_brk, ev_ascii, out_valid,
        input  out_ready
    );

    modport slave (
        input  ev_code, ev_ext, ev_brk, ev_ascii, out_valid,
        output out_ready
    );

endinterface

// File: rtl/ps2_set2_ascii.sv
// ps2_set2_ascii: combinational Set-2 scan code -> US ASCII lookup.
//   code  : make code (prefixes already stripped)
//   shift : shift held
//   ascii : translated character, 8'h00 when unmapped
// Covers letters, digits with US shifted symbols, space, enter, backspace, tab.
module ps2_set2_ascii (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);

    function automatic logic [7:0] letter(input logic [7:0] lower, input logic s);
        return s ? (lower - 8'h20) : lower;
    endfunction

    function automatic logic [7:0] pick(input logic [7:0] plain, input logic [7:0] shifted,
                                        input logic s);
        return s ? shifted : plain;
    endfunction

    always_comb begin
        ascii = '0;
        case (code)
            8'h1C: ascii = letter(8'h61, shift);
            8'h32: ascii = letter(8'h62, shift);
            8'h21: ascii = letter(8'h63, shift);
            8'h23: ascii = letter(8'h64, shift);
            8'h24: ascii = letter(8'h65, shift);
            8'h2B: ascii = letter(8'h66, shift);
            8'h34: ascii = letter(8'h67, shift);
            8'h33: ascii = letter(8'h68, shift);
            8'h43: ascii = letter(8'h69, shift);
            8'h3B: ascii = letter(8'h6A, shift);
            8'h42: ascii = letter(8'h6B, shift);
            8'h4B: ascii = letter(8'h6C, shift);
            8'h3A: ascii = letter(8'h6D, shift);
            8'h31: ascii = letter(8'h6E, shift);
            8'h44: ascii = letter(8'h6F, shift);
            8'h4D: ascii = letter(8'h70, shift);
            8'h15: ascii = letter(8'h71, shift);
            8'h2D: ascii = letter(8'h72, shift);
            8'h1B: ascii = letter(8'h73, shift);
            8'h2C: ascii = letter(8'h74, shift);
            8'h3C: ascii = letter(8'h75, shift);
            8'h2A: ascii = letter(8'h76, shift);
            8'h1D: ascii = letter(8'h77, shift);
            8'h22: ascii = letter(8'h78, shift);
            8'h35: ascii = letter(8'h79, shift);
            8'h1A: ascii = letter(8'h7A, shift);
            8'h45: ascii = pick(8'h30, 8'h29, shift);
            8'h16: ascii = pick(8'h31, 8'h21, shift);
            8'h1E: ascii = pick(8'h32, 8'h40, shift);
            8'h26: ascii = pick(8'h33, 8'h23, shift);
            8'h25: ascii = pick(8'h34, 8'h24, shift);
            8'h2E: ascii = pick(8'h35, 8'h25, shift);
            8'h36: ascii = pick(8'h36, 8'h5E, shift);
            8'h3D: ascii = pick(8'h37, 8'h26, shift);
            8'h3E: ascii = pick(8'h38, 8'h2A, shift);
            8'h46: ascii = pick(8'h39, 8'h28, shift);
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            8'h66: ascii = 8'h08;
            8'h0D: ascii = 8'h09;
            default: ascii = '0;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: PS/2 Set-2 byte stream -> buffered key events.
//   clk, rst       : system clock, asynchronous active-low reset
//   code_in        : scan byte, stable while code_valid is high
//   code_valid     : receiver frame strobe, asynchronous to clk
//   ev_if (master) : show-ahead event FIFO head with valid/ready pop
//   overflow       : sticky, an event was dropped on a full FIFO
//   shift_state    : left or right shift held
//   caps_lock      : caps flag, present only when PS2_CAPS_LOCK_EN is defined
// Optional feature macro: PS2_CAPS_LOCK_EN.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             code_in,
    input  logic                   code_valid,
    ps2_scancode_decoder_if.master ev_if,
    output logic                   overflow,
`ifdef PS2_CAPS_LOCK_EN
    output logic                   shift_state,
    output logic                   caps_lock
`else
    output logic                   shift_state
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    // ---------------- code_valid synchroniser and rising-edge strobe
    // Flops reset to 1 so a code_valid already high at reset release is ignored.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   strobe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], code_valid};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;

    // ---------------- ASCII translation
    logic       shift_l_q, shift_r_q;
    logic       shift_now;
    logic [7:0] ascii_raw;
    logic [7:0] ascii_sel;

    assign shift_now = shift_l_q | shift_r_q;

    ps2_set2_ascii u_ascii (
        .code  (code_in),
        .shift (shift_now),
        .ascii (ascii_raw)
    );

`ifdef PS2_CAPS_LOCK_EN
    logic caps_q;
    // Letters come back already cased by shift; caps inverts that case,
    // giving shift XOR caps as the uppercase selector.
    always_comb begin
        ascii_sel = ascii_raw;
        if (caps_q && ((ascii_raw >= 8'h61 && ascii_raw <= 8'h7A) ||
                       (ascii_raw >= 8'h41 && ascii_raw <= 8'h5A)))
            ascii_sel = ascii_raw ^ 8'h20;
    end
`else
    assign ascii_sel = ascii_raw;
`endif

    // ---------------- prefix FSM
    ps2_state_e state_q, state_d;
    logic       emit;
    ps2_event_t new_ev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        emit       = 1'b0;
        new_ev     = '0;
        new_ev.code = code_in;
        if (strobe) begin
            case (state_q)
                IDLE: begin
                    if (code_in == CODE_BRK)      state_d = BRK;
                    else if (code_in == CODE_EXT) state_d = EXT;
                    else if (!is_status(code_in)) emit = 1'b1;
                end
                EXT: begin
                    if (code_in == CODE_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        emit       = 1'b1;
                        new_ev.ext = 1'b1;
                        state_d    = IDLE;
                    end
                end
                BRK: begin
                    emit       = 1'b1;
                    new_ev.brk = 1'b1;
                    state_d    = IDLE;
                end
                EXT_BRK: begin
                    emit       = 1'b1;
                    new_ev.ext = 1'b1;
                    new_ev.brk = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        new_ev.ascii = (new_ev.ext || new_ev.brk) ? 8'h00 : ascii_sel;
    end

    // ---------------- shift / caps tracking (non-extended only, after the event)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
        end else if (emit && !new_ev.ext) begin
            if (new_ev.code == CODE_SHIFT_L) shift_l_q <= ~new_ev.brk;
            if (new_ev.code == CODE_SHIFT_R) shift_r_q <= ~new_ev.brk;
        end
    end

    assign shift_state = shift_now;

`ifdef PS2_CAPS_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            caps_q <= 1'b0;
        else if (emit && !new_ev.ext && !new_ev.brk && new_ev.code == CODE_CAPS)
            caps_q <= ~caps_q;
    end

    assign caps_lock = caps_q;
`endif

    // ---------------- show-ahead event FIFO
    ps2_event_t      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = ~empty & ev_if.out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push  = emit & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_ev;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (emit && !push) overflow <= 1'b1;
        end
    end

    assign ev_if.ev_code   = mem[rd_ptr].code;
    assign ev_if.ev_ext    = mem[rd_ptr].ext;
    assign ev_if.ev_brk    = mem[rd_ptr].brk;
    assign ev_if.ev_ascii  = mem[rd_ptr].ascii;
    assign ev_if.out_valid = ~empty;

endmodule
